// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: TXDATA/STATUS/CTRL register window,
// byte FIFO and a registered-output transmit FSM.
module mmio_uart_tx #(
    parameter logic [31:0] BASE_ADDR    = 32'h0000_1000,
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] m_addr,
    input  logic [31:0] m_wr_dat,
    input  logic        wr_en,
    input  logic        rd_en,
    output logic [31:0] m_rd_dat,
    output logic        sel,
    output logic        tx,
    output logic        tx_busy
);
    localparam int unsigned AW        = $clog2(FIFO_DEPTH);
    localparam logic [AW:0] DEPTH_C   = FIFO_DEPTH[AW:0];
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_e;

    logic [7:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          ovf_q, en_q;
    state_e        state_q, state_d;
    logic [15:0]   baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [1:0] reg_idx;
    logic       wr_txdata, wr_status, wr_ctrl;
    logic       full, empty, push, drop, pop;
    logic [6:0] cnt_ext;
    logic       unused_bits;

    assign reg_idx   = m_addr[3:2];
    assign sel       = (m_addr[31:4] == BASE_ADDR[31:4]) && (reg_idx != 2'd3);
    assign wr_txdata = sel && wr_en && (reg_idx == 2'd0);
    assign wr_status = sel && wr_en && (reg_idx == 2'd1);
    assign wr_ctrl   = sel && wr_en && (reg_idx == 2'd2);

    assign full  = (count_q == DEPTH_C);
    assign empty = (count_q == '0);
    // A full FIFO still accepts a byte when the FSM pops on the same edge.
    assign push  = wr_txdata && (!full || pop);
    assign drop  = wr_txdata && !push;

    assign unused_bits = ^{m_addr[1:0], m_wr_dat[31:8]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= m_wr_dat[7:0];
    end

    // Overflow set takes priority over a same-cycle software clear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_q <= 1'b0;
            en_q  <= 1'b1;
        end else begin
            if (drop)                        ovf_q <= 1'b1;
            else if (wr_status && m_wr_dat[3]) ovf_q <= 1'b0;
            if (wr_ctrl) en_q <= m_wr_dat[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        pop     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!empty && en_q) begin
                    state_d = S_START;
                    pop     = 1'b1;
                    shift_d = mem_q[rd_ptr_q];
                    baud_d  = '0;
                    bit_d   = '0;
                end
            end
            S_START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = S_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            S_STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (!empty && en_q) begin
                        state_d = S_START;
                        pop     = 1'b1;
                        shift_d = mem_q[rd_ptr_q];
                        bit_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // Line level follows the state being entered so tx stays a pure flop.
        case (state_d)
            S_START: tx_d = 1'b0;
            S_DATA:  tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    assign cnt_ext = 7'(count_q);

    always_comb begin
        m_rd_dat = '0;
        if (sel && rd_en) begin
            case (reg_idx)
                2'd1:    m_rd_dat = {17'd0, cnt_ext, 4'd0, ovf_q, (state_q != S_IDLE), empty, full};
                2'd2:    m_rd_dat = {31'd0, en_q};
                default: m_rd_dat = '0;
            endcase
        end
    end

    assign tx      = tx_q;
    assign tx_busy = (state_q != S_IDLE) || !empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Scoreboarded bench: stimulus queues expected bytes, a line receiver decodes
// tx frames and checks them against the queue, plus register/timing checks.
module tb_mmio_uart_tx;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam logic [31:0] BASE = 32'h0000_1000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] m_addr, m_wr_dat, m_rd_dat;
    logic        wr_en, rd_en, sel, tx, tx_busy;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .m_addr(m_addr), .m_wr_dat(m_wr_dat),
        .wr_en(wr_en), .rd_en(rd_en), .m_rd_dat(m_rd_dat), .sel(sel),
        .tx(tx), .tx_busy(tx_busy)
    );

    always #5 clk = ~clk;

    int errors = 0, checks = 0, cyc = 0, frames = 0;
    logic [7:0] exp_q[$];
    int         start_q[$];
    logic       rx_act = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] status_of(input int cnt, input bit ovf, input bit act);
        return (32'(cnt) << 8) | (ovf ? 32'h8 : 32'h0) | (act ? 32'h4 : 32'h0)
             | ((cnt == 0) ? 32'h2 : 32'h0) | ((cnt == DEPTH) ? 32'h1 : 32'h0);
    endfunction

    // Line receiver: decodes 8N1 frames sampled mid-bit, independent of stimulus.
    initial begin : monitor
        int ph;
        logic [7:0] b;
        logic [7:0] e;
        ph = 0; b = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                rx_act = 1'b0;
            end else if (!rx_act) begin
                if (tx === 1'b0) begin
                    rx_act = 1'b1;
                    ph = 0;
                    start_q.push_back(cyc);
                end
            end else begin
                ph++;
                if (ph == CPB / 2) chk("start_bit", 32'(tx), 32'h0);
                if (ph >= CPB + CPB / 2 && ph < 9 * CPB && (ph % CPB) == CPB / 2)
                    b[(ph - CPB) / CPB] = tx;
                if (ph == 9 * CPB + CPB / 2) begin
                    chk("stop_bit", 32'(tx), 32'h1);
                    frames++;
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: got byte 0x%02h, none expected", b);
                    end else begin
                        e = exp_q.pop_front();
                        chk("rx_byte", 32'(b), 32'(e));
                    end
                end
                if (ph == 10 * CPB - 1) rx_act = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        m_addr = a; m_wr_dat = d; wr_en = 1'b1;
        @(posedge clk); #1;
        wr_en = 1'b0;
    endtask

    task automatic bus_rd(input logic [31:0] a, input logic en, output logic [31:0] d, output logic s);
        m_addr = a; rd_en = en;
        #1;
        d = m_rd_dat; s = sel;
        rd_en = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n;
        n = 0;
        while ((tx_busy !== 1'b0 || rx_act) && n < maxc) begin
            @(posedge clk); n++;
        end
        if (n >= maxc) begin
            checks++; errors++;
            $display("FAIL idle_timeout: still busy after %0d cycles", maxc);
        end
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [31:0] d;
        logic        s;
        logic [7:0]  b;
        logic [9:0]  fr;
        logic [7:0]  rb [2];
        int          f0, n, burst;

        m_addr = '0; m_wr_dat = '0; wr_en = 1'b0; rd_en = 1'b0;
        rb[0] = 8'hFF; rb[1] = 8'h00;

        // Reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_tx", 32'(tx), 32'h1);
        chk("rst_busy", 32'(tx_busy), 32'h0);
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("rst_status", d, status_of(0, 1'b0, 1'b0));
        bus_rd(BASE + 8, 1'b1, d, s);
        chk("rst_ctrl", d, 32'h1);
        reset = 1'b1;
        @(posedge clk); #1;

        // Single byte: exact line waveform and busy release
        b  = 8'h55;
        fr = {1'b1, b, 1'b0};
        exp_q.push_back(b);
        bus_wr(BASE, 32'(b));
        for (int k = 1; k <= 41; k++) begin
            @(posedge clk); #2;
            if (k <= 40) chk("t1_tx_wave", 32'(tx), 32'(fr[(k - 1) / CPB]));
            if (k == 40) chk("t1_busy_end", 32'(tx_busy), 32'h1);
            if (k == 41) chk("t1_busy_fall", 32'(tx_busy), 32'h0);
        end
        wait_idle(100);

        // Back-to-back frames with no gap
        start_q.delete();
        exp_q.push_back(8'hA3);
        exp_q.push_back(8'h0F);
        bus_wr(BASE, 32'hA3);
        bus_wr(BASE, 32'h0F);
        repeat (20) @(posedge clk); #1;
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t2_status_mid", d, status_of(1, 1'b0, 1'b1));
        wait_idle(200);
        chk("t2_frames", 32'(start_q.size()), 32'd2);
        if (start_q.size() == 2)
            chk("t2_spacing", 32'(start_q[1] - start_q[0]), 32'(10 * CPB));

        // Disabled: overflow on the ninth byte, clear, then drain
        bus_wr(BASE + 8, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b);
            bus_wr(BASE, 32'(b));
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("t3_tx_held", 32'(tx), 32'h1);
        end
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t3_status_ovf", d, status_of(DEPTH, 1'b1, 1'b0));
        bus_wr(BASE + 4, 32'h8);
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t3_status_clr", d, status_of(DEPTH, 1'b0, 1'b0));
        f0 = frames;
        bus_wr(BASE + 8, 32'h1);
        wait_idle(2000);
        chk("t3_drain", 32'(frames - f0), 32'(DEPTH));

        // Full FIFO, write lands on the pop edge
        bus_wr(BASE + 8, 32'h0);
        for (int i = 0; i < DEPTH; i++) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            bus_wr(BASE, 32'(b));
        end
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t4_full", d, status_of(DEPTH, 1'b0, 1'b0));
        f0 = frames;
        b = 8'($urandom);
        exp_q.push_back(b);
        bus_wr(BASE + 8, 32'h1);
        bus_wr(BASE, 32'(b));
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t4_pop_push", d, status_of(DEPTH, 1'b0, 1'b1));
        wait_idle(2000);
        chk("t4_drain", 32'(frames - f0), 32'(DEPTH + 1));

        // Reset during data bit 3
        for (int r = 0; r < 2; r++) begin
            b = rb[r];
            exp_q.push_back(b);
            bus_wr(BASE, 32'(b));
            repeat (18) @(posedge clk); #2;
            chk("t5_pre_bit3", 32'(tx), 32'(b[3]));
            reset = 1'b0;
            #1;
            chk("t5_async_tx", 32'(tx), 32'h1);
            chk("t5_async_busy", 32'(tx_busy), 32'h0);
            exp_q.delete();
            repeat (2) @(posedge clk);
            @(negedge clk);
            reset = 1'b1;
            @(posedge clk); #1;
            bus_rd(BASE + 4, 1'b1, d, s);
            chk("t5_status", d, status_of(0, 1'b0, 1'b0));
            f0 = frames;
            n = 0;
            for (int i = 0; i < 60; i++) begin
                @(posedge clk); #1;
                if (tx !== 1'b1) n++;
            end
            chk("t5_no_residual", 32'(n), 32'h0);
            chk("t5_no_frame", 32'(frames - f0), 32'h0);
        end

        // Decode edges and STATUS write masking
        bus_rd(BASE + 12, 1'b1, d, s);
        chk("t6_hole_sel", 32'(s), 32'h0);
        chk("t6_hole_dat", d, 32'h0);
        bus_rd(32'h0000_2004, 1'b1, d, s);
        chk("t6_out_sel", 32'(s), 32'h0);
        chk("t6_out_dat", d, 32'h0);
        bus_rd(BASE + 6, 1'b1, d, s);
        chk("t6_lowbits", d, status_of(0, 1'b0, 1'b0));
        bus_rd(BASE + 4, 1'b0, d, s);
        chk("t6_no_rden", d, 32'h0);
        bus_rd(BASE + 1, 1'b1, d, s);
        chk("t6_txdata_rd", d, 32'h0);
        bus_wr(BASE + 12, 32'h0);
        bus_wr(32'h0000_2008, 32'h0);
        bus_rd(BASE + 8, 1'b1, d, s);
        chk("t6_ctrl_kept", d, 32'h1);
        bus_wr(BASE + 8, 32'hFFFF_FFFE);
        bus_rd(BASE + 8, 1'b1, d, s);
        chk("t6_ctrl_off", d, 32'h0);
        for (int i = 0; i < DEPTH + 1; i++) begin
            b = 8'($urandom);
            if (i < DEPTH) exp_q.push_back(b);
            bus_wr(BASE, 32'(b));
        end
        bus_wr(BASE + 4, 32'hFF);
        bus_rd(BASE + 4, 1'b1, d, s);
        chk("t6_status_ff", d, status_of(DEPTH, 1'b0, 1'b0));
        bus_wr(BASE + 8, 32'h1);
        wait_idle(2000);

        // Randomised bursts with random spacing
        for (int k = 0; k < 6; k++) begin
            burst = $urandom_range(1, DEPTH - 1);
            for (int i = 0; i < burst; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                bus_wr(BASE + 32'($urandom_range(0, 3)), 32'($urandom) & 32'hFFFF_FF00 | 32'(b));
                repeat ($urandom_range(0, 3)) @(posedge clk);
                #1;
            end
            wait_idle(2000);
        end

        chk("final_scoreboard_empty", 32'(exp_q.size()), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mmio_uart_tx.md
Name: mmio_uart_tx

Overview:
- Memory-mapped UART transmitter on the core's data-memory bus, alongside the data memory.
- Consumes store traffic (m_addr, m_wr_dat, MemWrite) in its address window and serialises bytes as 8N1 frames on one tx pin.
- Contains a byte FIFO, status/control registers, and a transmit FSM.
- Top level decodes the returned sel to mux m_rd_dat between the data memory and this block.

Parameters:
- BASE_ADDR, 32'h0000_1000, word-aligned base of the 3-register window.
- CLKS_PER_BIT, 16, clock cycles per serial bit. Legal range 2 to 65535.
- FIFO_DEPTH, 8, byte FIFO entries. Power of two, 2 to 64.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- reset  input  1  asynchronous, active-low reset
- m_addr  input  32  byte address from core
- m_wr_dat  input  32  store data from core
- wr_en  input  1  store strobe (MemWrite)
- rd_en  input  1  load strobe (MemRead)
- m_rd_dat  output  32  register read data, combinational
- sel  output  1  high when m_addr[31:4] matches BASE_ADDR[31:4] and m_addr[3:2] is at most 2
- tx  output  1  serial line, idle high
- tx_busy  output  1  high when the FSM is not IDLE or the FIFO is non-empty

Behaviour:
- Register map (word offsets):
  - +0 TXDATA: write pushes m_wr_dat[7:0]; reads return 0.
  - +4 STATUS, read-only except bit3:
    - bit0 full, bit1 empty, bit2 active (FSM not IDLE), bit3 overflow (sticky)
    - bits[14:8] FIFO count; all other bits 0
    - writing bit3=1 clears overflow; other written bits are ignored.
  - +8 CTRL: bit0 enable, reset value 1; other bits read 0.
- Bus decode:
  - Accesses with sel low are ignored.
  - m_rd_dat = selected register when sel and rd_en, else 0.
  - Address bits [1:0] are ignored.
- Reset (async assert, sync release):
  - tx=1, tx_busy=0, FIFO empty, overflow=0, enable=1, FSM=IDLE, counters 0.
  - Mid-frame reset aborts the frame; tx goes high immediately.
- FIFO:
  - Push on a TXDATA write when not full, or when full and a pop occurs in the same cycle.
  - A push that would otherwise fail is dropped and sets overflow. FIFO contents are unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Count saturates exactly at FIFO_DEPTH.
  - Simultaneous push and pop leaves count unchanged.
  - Simultaneous overflow-set and clear: set wins.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE -> START when FIFO non-empty and enable=1. Pop the head byte into the shift register on that edge; bit counter=0, baud counter=0.
  - START: tx=0 for CLKS_PER_BIT cycles, then -> DATA.
  - DATA: tx = shift[0], LSB first. Each bit lasts CLKS_PER_BIT cycles, then shift right. After bit 7 -> STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then -> START with an immediate pop if the FIFO is non-empty and enable=1, else -> IDLE.
  - Back-to-back frames have no idle gap. A frame is exactly 10*CLKS_PER_BIT cycles.
- Latency: a push at edge T into an empty FIFO with FSM IDLE gives tx=0 from edge T+1.
- Enable:
  - Clearing enable mid-frame lets the current frame complete, then the FSM holds in IDLE.
  - Writes continue to queue while disabled.
- tx is registered; no combinational path from bus inputs to tx.

Test Plan:
- CLKS_PER_BIT=4. Write 0x55 to BASE+0 at edge T -> tx=0 over T+1..T+4, then 1,0,1,0,1,0,1,0 each 4 cycles, then 1 for 4 cycles. tx_busy falls at T+41.
- Write 0xA3 then 0x0F on consecutive cycles -> two frames back-to-back, 80 cycles total, no idle-high gap between frames. STATUS count reads 1 during the first frame.
- CTRL.enable=0, then write 9 bytes with FIFO_DEPTH=8 -> STATUS reads full=1, overflow=1, count=8, tx stays 1. Write STATUS=0x8 -> overflow=0. Set enable=1 -> 8 frames are sent.
- FIFO full and FSM popping on the same edge as a TXDATA write -> byte accepted, count stays 8, overflow stays 0.
- Assert reset low during DATA bit 3 of 0xFF -> tx=1 asynchronously, STATUS reads 0x2 after release, no residual frame.
- Read BASE+12 and an address outside the window with rd_en=1 -> sel=0, m_rd_dat=0; a write to BASE+4 with value 0xFF changes only overflow.
